// File: rtl/conv_win_addr_gen.sv
// conv_win_addr_gen
// Read-address sequencer for one stride-1 convolution layer. It walks a KxK
// window across an IN_W x IN_H feature map. It presents one buffer read
// address per beat on a valid/ready handshake.
// The row base is kept incrementally, so the output path has no multiplier.
module conv_win_addr_gen #(
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              i_start,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_win_first,
    output logic              o_win_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int OUT_W = IN_W - K + 1;
    localparam int OUT_H = IN_H - K + 1;

    localparam logic [CNT_W-1:0]  K_MAX    = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]  OW_MAX   = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0]  OH_MAX   = CNT_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IN_W);
    localparam logic              K_IS_ONE = (K == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   kx_q, ky_q, ox_q, oy_q;
    logic [CNT_W-1:0]   kx_d, ky_d, ox_d, oy_d;
    // col_q = ox+kx; oy_base_q = oy*IN_W; row_base_q = (oy+ky)*IN_W
    logic [CNT_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]  oy_base_q, oy_base_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               first_d, last_d;
    logic               last_beat_s;

    logic               valid_q, first_q, last_q, busy_q, done_q;
    logic [ADDR_W-1:0]  addr_q;

    assign o_valid     = valid_q;
    assign o_addr      = addr_q;
    assign o_win_first = first_q;
    assign o_win_last  = last_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

    // Next window position and its address, assuming the current beat is accepted
    always_comb begin
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        col_d      = col_q;
        oy_base_d  = oy_base_q;
        row_base_d = row_base_q;
        if (kx_q != K_MAX) begin
            kx_d  = kx_q + 1'b1;
            col_d = col_q + 1'b1;
        end else begin
            kx_d = {CNT_W{1'b0}};
            if (ky_q != K_MAX) begin
                ky_d       = ky_q + 1'b1;
                col_d      = ox_q;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                ky_d       = {CNT_W{1'b0}};
                row_base_d = oy_base_q;
                if (ox_q != OW_MAX) begin
                    ox_d  = ox_q + 1'b1;
                    col_d = ox_q + 1'b1;
                end else begin
                    ox_d  = {CNT_W{1'b0}};
                    col_d = {CNT_W{1'b0}};
                    if (oy_q != OH_MAX) begin
                        oy_d       = oy_q + 1'b1;
                        oy_base_d  = oy_base_q + ROW_STEP;
                        row_base_d = oy_base_q + ROW_STEP;
                    end else begin
                        oy_d       = {CNT_W{1'b0}};
                        oy_base_d  = {ADDR_W{1'b0}};
                        row_base_d = {ADDR_W{1'b0}};
                    end
                end
            end
        end
        addr_d  = row_base_d + ADDR_W'(col_d);
        first_d = (kx_d == {CNT_W{1'b0}}) && (ky_d == {CNT_W{1'b0}});
        last_d  = (kx_d == K_MAX) && (ky_d == K_MAX);
    end

    // The current beat is the final window element of the pass
    always_comb begin
        last_beat_s = (kx_q == K_MAX) && (ky_q == K_MAX) &&
                      (ox_q == OW_MAX) && (oy_q == OH_MAX);
    end

    // Pass FSM: counters, registered address/flags and status outputs
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q    <= ST_IDLE;
            kx_q       <= {CNT_W{1'b0}};
            ky_q       <= {CNT_W{1'b0}};
            ox_q       <= {CNT_W{1'b0}};
            oy_q       <= {CNT_W{1'b0}};
            col_q      <= {CNT_W{1'b0}};
            oy_base_q  <= {ADDR_W{1'b0}};
            row_base_q <= {ADDR_W{1'b0}};
            valid_q    <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_q    <= ST_RUN;
                        kx_q       <= {CNT_W{1'b0}};
                        ky_q       <= {CNT_W{1'b0}};
                        ox_q       <= {CNT_W{1'b0}};
                        oy_q       <= {CNT_W{1'b0}};
                        col_q      <= {CNT_W{1'b0}};
                        oy_base_q  <= {ADDR_W{1'b0}};
                        row_base_q <= {ADDR_W{1'b0}};
                        valid_q    <= 1'b1;
                        addr_q     <= {ADDR_W{1'b0}};
                        first_q    <= 1'b1;
                        last_q     <= K_IS_ONE;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A stray start pulse here is ignored; only acceptance advances
                    if (i_ready && valid_q) begin
                        if (last_beat_s) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            kx_q       <= kx_d;
                            ky_q       <= ky_d;
                            ox_q       <= ox_d;
                            oy_q       <= oy_d;
                            col_q      <= col_d;
                            oy_base_q  <= oy_base_d;
                            row_base_q <= row_base_d;
                            addr_q     <= addr_d;
                            first_q    <= first_d;
                            last_q     <= last_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Directed bench for conv_win_addr_gen: default 28x28/K=5 instance plus a
// 14x14 override instance. A small window-walk model provides expected beats.
module tb_conv_win_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       global_rst_n;
    logic       start_a, ready_a, start_b, ready_b;
    logic       valid_a, first_a, last_a, busy_a, done_a;
    logic [9:0] addr_a;
    logic       valid_b, first_b, last_b, busy_b, done_b;
    logic [7:0] addr_b;

    int checks = 0;
    int errors = 0;
    int cap [0:25];

    conv_win_addr_gen dut_a (
        .clk(clk), .global_rst_n(global_rst_n), .i_start(start_a), .i_ready(ready_a),
        .o_valid(valid_a), .o_addr(addr_a), .o_win_first(first_a), .o_win_last(last_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    conv_win_addr_gen #(.IN_W(14), .IN_H(14), .K(5), .ADDR_W(8)) dut_b (
        .clk(clk), .global_rst_n(global_rst_n), .i_start(start_b), .i_ready(ready_b),
        .o_valid(valid_b), .o_addr(addr_b), .o_win_first(first_b), .o_win_last(last_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the first beat is shown
    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Walk the default-size pass beat by beat against the model
    task automatic run_a(input bit rnd, input int pulse_beat, input int abort_beat,
                         output int nbeats, output int last_addr);
        int kx = 0, ky = 0, ox = 0, oy = 0, cyc = 0, e0, exp_addr, obs_addr;
        bit ok = 1'b1;
        bit acc;
        nbeats = 0;
        last_addr = -1;
        while (ok && nbeats < 14400 && cyc < 40000) begin
            if (nbeats == abort_beat) break;
            ready_a  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_a  = (nbeats == pulse_beat);
            exp_addr = (oy + ky) * 28 + ox + kx;
            obs_addr = int'(addr_a);
            if (!rnd && nbeats < 26) cap[nbeats] = obs_addr;
            e0 = errors;
            chk("beat", 32'({valid_a, addr_a, first_a, last_a}),
                32'({1'b1, 10'(exp_addr), 1'(kx == 0 && ky == 0), 1'(kx == 4 && ky == 4)}));
            if (errors != e0) ok = 1'b0;
            acc = ready_a;
            @(posedge clk);
            if (acc) begin
                last_addr = obs_addr;
                nbeats++;
                if (kx < 4) kx++;
                else begin
                    kx = 0;
                    if (ky < 4) ky++;
                    else begin
                        ky = 0;
                        if (ox < 23) ox++;
                        else begin
                            ox = 0;
                            oy++;
                        end
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
    endtask

    initial begin
        int n, la, nb, lb, cyc;
        global_rst_n = 1'b0;
        start_a = 1'b0; ready_a = 1'b0;
        start_b = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_addr",  32'(addr_a),  32'd0);
        chk("rst_first", 32'(first_a), 32'd0);
        chk("rst_last",  32'(last_a),  32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_done",  32'(done_a),  32'd0);
        chk("rst_b",     32'({valid_b, done_b, busy_b}), 32'd0);
        global_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", 32'(valid_a), 32'd0);

        // Pass 1: ready always high
        ready_a = 1'b1;
        pulse_start_a();
        chk("start_busy", 32'(busy_a), 32'd1);
        chk("start_done", 32'(done_a), 32'd0);
        run_a(1'b0, -1, -1, n, la);
        chk("p1_beats", 32'(n),  32'd14400);
        chk("p1_last",  32'(la), 32'd783);
        chk("cap0",  32'(cap[0]),  32'd0);
        chk("cap1",  32'(cap[1]),  32'd1);
        chk("cap2",  32'(cap[2]),  32'd2);
        chk("cap3",  32'(cap[3]),  32'd3);
        chk("cap4",  32'(cap[4]),  32'd4);
        chk("cap5",  32'(cap[5]),  32'd28);
        chk("cap6",  32'(cap[6]),  32'd29);
        chk("cap24", 32'(cap[24]), 32'd116);
        chk("cap25", 32'(cap[25]), 32'd1);
        chk("end_status", 32'({valid_a, busy_a, first_a, last_a, done_a}), 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hold_done", 32'({valid_a, done_a}), 32'd1);
        end

        // Pass 2: restart from DONE, random ready, stray start at beat 500
        pulse_start_a();
        chk("restart", 32'({done_a, valid_a, first_a, addr_a}), 32'({1'b0, 1'b1, 1'b1, 10'd0}));
        run_a(1'b1, 500, -1, n, la);
        chk("p2_beats", 32'(n),  32'd14400);
        chk("p2_last",  32'(la), 32'd783);
        chk("p2_done",  32'({valid_a, done_a}), 32'd1);

        // Pass 3: reset asserted mid-pass at beat 3000
        pulse_start_a();
        run_a(1'b0, -1, 3000, n, la);
        chk("p3_beats", 32'(n), 32'd3000);
        global_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_addr",  32'(addr_a),  32'd0);
        chk("arst_flags", 32'({first_a, last_a}), 32'd0);
        chk("arst_busy",  32'(busy_a),  32'd0);
        chk("arst_done",  32'(done_a),  32'd0);
        @(negedge clk);
        global_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", 32'({valid_a, done_a, busy_a}), 32'd0);

        // Override instance: 14x14, K=5
        ready_b = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        chk("b_first", 32'({valid_b, first_b, addr_b}), 32'({1'b1, 1'b1, 8'd0}));
        nb = 0; lb = -1; cyc = 0;
        while (valid_b && cyc < 3000) begin
            lb = int'(addr_b);
            @(posedge clk);
            nb++;
            @(negedge clk);
            cyc++;
        end
        chk("b_beats", 32'(nb), 32'd2500);
        chk("b_last",  32'(lb), 32'd195);
        chk("b_done",  32'(done_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_win_addr_gen.md
Name: conv_win_addr_gen

Overview:
- Read-address sequencer for one convolution layer of the LeNet accelerator.
- Walks a KxK stride-1 window over an IN_W x IN_H feature-map buffer and emits one buffer read address per beat over a valid/ready handshake.
- Sits upstream of the MAC array and of the per-layer done/counter logic.
- Provides window-boundary flags and a sticky done flag that the layer controller polls.

Parameters:
- IN_W, 28, input feature-map width in pixels.
- IN_H, 28, input feature-map height in pixels.
- K, 5, kernel size (square).
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= IN_W*IN_H.
- CNT_W, 5, width of the internal kx/ky/ox/oy counters; must hold max(IN_W, IN_H)-1.

Ports:
- clk  input  1  clock, rising edge.
- global_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle pulse that starts a layer pass.
- i_ready  input  1  downstream accepts the current beat.
- o_valid  output  1  o_addr and the flags are valid.
- o_addr  output  ADDR_W  feature-map read address.
- o_win_first  output  1  current beat is kx=0, ky=0 of a window.
- o_win_last  output  1  current beat is kx=K-1, ky=K-1 of a window.
- o_busy  output  1  FSM is in RUN.
- o_done  output  1  sticky pass-complete flag.

Behaviour:
- Reset: the clk/global_rst_n reset is asynchronous, active-low. Reset forces the FSM to IDLE, all counters to 0, and o_valid, o_addr, o_win_first, o_win_last, o_busy and o_done to 0.
- Derived values: OUT_W = IN_W-K+1 and OUT_H = IN_H-K+1 (24x24 at defaults).
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with i_start=1 -> RUN on the next edge:
  - kx, ky, ox and oy are cleared.
  - o_done is cleared.
  - o_valid=1 with o_addr=0 and o_win_first=1 in the first RUN cycle. Start-to-first-valid latency is 1 cycle.
- RUN: o_valid is held at 1. A beat is accepted when o_valid && i_ready.
  - The counters advance only on an accepted beat.
  - Counter order: kx innermost, then ky, then ox, then oy.
  - Each counter wraps to 0 at its limit (K-1, K-1, OUT_W-1, OUT_H-1) and carries into the next counter.
- Address: o_addr = (oy+ky)*IN_W + (ox+kx), computed on the values after the advance and registered.
  - No combinational multiplier is allowed in the output path; the row base is maintained incrementally (+IN_W, -(K-1)*IN_W, etc.).
  - The result must never exceed IN_W*IN_H-1.
- Flags: o_win_first and o_win_last are registered alongside o_addr and refer to the beat currently presented.
- Backpressure: while i_ready=0, o_addr and all flags hold their values and o_valid stays 1. A valid beat is never withdrawn.
- Final beat: the beat with kx=K-1, ky=K-1, ox=OUT_W-1, oy=OUT_H-1 has address (IN_H-1)*IN_W + IN_W-1. When it is accepted:
  - The FSM moves to DONE.
  - o_valid, o_busy, o_win_first and o_win_last are 0 from the next cycle.
  - o_done=1 and stays 1 until the next i_start or reset.
- i_start while in RUN is ignored; there is no restart.
- Beat count: exactly OUT_W*OUT_H*K*K beats per pass (14400 at defaults).
- o_busy = (state==RUN).
- Reset mid-pass: returns immediately to IDLE with all outputs at 0; no partial done.

Test Plan:
- Reset, pulse i_start, i_ready=1 throughout -> first 7 addresses are 0,1,2,3,4,28,29; o_win_first=1 only on addr 0; o_win_last=1 on the 25th beat (addr 116); the 26th beat has addr 1 with o_win_first=1.
- Full pass with i_ready=1 -> exactly 14400 beats; last addr=783 with o_win_last=1; o_valid=0 and o_done=1 the following cycle; o_done holds for 100 idle cycles.
- Random i_ready (50%) -> the address sequence matches a golden model beat-for-beat; o_addr is stable on every cycle with i_ready=0; beat count is still 14400.
- i_start pulsed mid-pass at beat 500 -> ignored, the sequence continues unchanged. After DONE, i_start -> o_done clears the next cycle and the pass restarts at addr 0.
- global_rst_n asserted at beat 3000 -> all outputs 0 asynchronously; after release the FSM stays IDLE (o_valid=0, o_done=0) until i_start.
- Parameter override IN_W=IN_H=14, K=5, ADDR_W=8 -> 10x10x25 = 2500 beats; last addr=195.
